rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//   Shares the single register-file write port between the in-order pipeline writeback (MEM/WB stage)
//   and a multi-cycle execution unit (mul/div) that returns results out of band. Pipeline writeback
//   always wins; multi-cycle results wait in a small FIFO. Keeps a per-register busy scoreboard for
//   the hazard unit and requests a pipeline bubble when a queued result starves.
// PARAMETERS
//   DATA_W        16  register data width
//   NREGS         16  register count (address width = $clog2(NREGS) = 4)
//   DEPTH          2  multi-cycle result FIFO depth (power of 2, >= 2)
//   STARVE_LIMIT   4  cycles a FIFO head may be blocked before starve_stall asserts
// PORTS
//   clk           in   1       clock, all state updates on rising edge
//   reset         in   1       asynchronous, active-high reset
//   wb_valid      in   1       pipeline writeback request (reg_write from MEM/WB)
//   wb_rd         in   4       pipeline destination register
//   wb_data       in   16      pipeline writeback data (already muxed mem/alu)
//   issue_valid   in   1       multi-cycle op issued this cycle (sets busy)
//   issue_rd      in   4       destination of issued multi-cycle op
//   mc_valid      in   1       multi-cycle result available
//   mc_ready      out  1       arbiter accepts result; = !fifo_full
//   mc_rd         in   4       result destination register
//   mc_data       in   16      result data
//   rf_we         out  1       register-file write enable (registered)
//   rf_waddr      out  4       register-file write address (registered)
//   rf_wdata      out  16      register-file write data (registered)
//   busy          out  16      busy[r]=1: multi-cycle write to r outstanding
//   starve_stall  out  1       request to hazard unit: insert bubble so FIFO head can write
// BEHAVIOUR
//   Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, starve_stall=0, FIFO empty
//     (mc_ready=1 after reset), age counter=0. Reset mid-operation discards queued results; the
//     multi-cycle unit is reset by the same signal.
//   Push: mc_valid && mc_ready -> {mc_rd,mc_data} enqueued at the edge. mc_ready depends only on
//     FIFO full (no same-cycle pop credit): full FIFO never accepts, even if it pops that cycle.
//   Arbitration (per cycle, evaluated on current inputs/state):
//     wb_valid=1            -> next rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data; FIFO holds.
//     wb_valid=0, !empty    -> pop head; next rf_we=1, rf_waddr/rf_wdata = head.
//     wb_valid=0, empty     -> next rf_we=0; rf_waddr/rf_wdata hold previous values.
//   Latency: pipeline path 1 cycle (input to rf_we). Multi-cycle path minimum 2 cycles
//     (push edge, pop edge); no bypass around the FIFO, even when empty.
//   Simultaneous push and pop on non-full FIFO: both occur; occupancy unchanged; order preserved.
//   Pointers wrap modulo DEPTH; full/empty via extra pointer bit (occupancy 0..DEPTH).
//   Scoreboard: issue_valid sets busy[issue_rd]; FIFO pop of entry rd clears busy[rd] at the same
//     edge rf_we is registered. Same-edge set and clear of same rd: set wins. Issue to an already
//     busy rd is illegal (hazard unit prevents it); no checking, busy stays 1.
//   Starvation: age counter increments each cycle FIFO non-empty and head blocked by wb_valid;
//     cleared on every pop or when empty; saturates at STARVE_LIMIT.
//     starve_stall registered: 1 when counter == STARVE_LIMIT, 0 the cycle after the blocked head
//     pops. Hazard unit responds by injecting wb_valid=0 bubbles; arbiter does not stall anything itself.
//   No combinational path from mc_valid to mc_ready; all outputs except mc_ready and busy readback
//     come from flops.
// TESTING
//   1. Reset mid-run with 2 queued results -> all outputs 0 immediately, mc_ready=1, busy=16'h0000, no later write.
//   2. wb_valid=1, wb_rd=3, wb_data=16'hBEEF, FIFO empty -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'hBEEF.
//   3. issue rd=5; later mc_valid rd=5 data=16'h1234 with wb_valid=0 -> busy[5]=1 until write
//      2 cycles after push; busy[5] clears same edge rf_we=1, rf_waddr=5.
//   4. Push rd=1,rd=2 with wb_valid=1 continuously -> mc_ready=0 after 2nd push; after 4 blocked
//      cycles starve_stall=1; wb_valid=0 one cycle -> rd=1 written, starve_stall drops; next idle writes rd=2.
//   5. Same-edge issue rd=7 and pop of rd=7 entry -> busy[7]=1 afterwards.
//   6. Random wb/mc/issue traffic, 10k cycles -> scoreboard model matches every rf write, FIFO order kept, no loss.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port: pipeline writeback first, queued multi-cycle results otherwise.
// Also keeps a per-register busy scoreboard and flags starvation of the queued head.
module rf_write_arbiter #(
  parameter int DATA_W       = 16,
  parameter int NREGS        = 16,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int AW          = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [AW-1:0]     mc_rd,
  input  logic [DATA_W-1:0] mc_data,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  busy,
  output logic              starve_stall
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int CW    = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  entry_t            head;

  logic [CW-1:0]     age;
  logic [CW-1:0]     age_nxt;
  logic [NREGS-1:0]  busy_nxt;
  logic              we_nxt;
  logic [AW-1:0]     waddr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign mc_ready = !full;
  assign push     = mc_valid && !full;
  assign pop      = !wb_valid && !empty;
  assign head     = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= '{rd: mc_rd, data: mc_data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_comb begin
    we_nxt    = 1'b0;
    waddr_nxt = rf_waddr;
    wdata_nxt = rf_wdata;
    if (wb_valid) begin
      we_nxt    = 1'b1;
      waddr_nxt = wb_rd;
      wdata_nxt = wb_data;
    end else if (pop) begin
      we_nxt    = 1'b1;
      waddr_nxt = head.rd;
      wdata_nxt = head.data;
    end
  end

  // Issue is applied after the pop clear so a same-edge set of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (pop)         busy_nxt[head.rd]  = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
  end

  // A non-empty FIFO that does not pop is necessarily blocked by wb_valid.
  always_comb begin
    age_nxt = age;
    if (pop || empty) begin
      age_nxt = '0;
    end else if (age != CW'(STARVE_LIMIT)) begin
      age_nxt = age + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      busy         <= '0;
      age          <= '0;
      starve_stall <= 1'b0;
    end else begin
      rf_we        <= we_nxt;
      rf_waddr     <= waddr_nxt;
      rf_wdata     <= wdata_nxt;
      busy         <= busy_nxt;
      age          <= age_nxt;
      starve_stall <= (age_nxt == CW'(STARVE_LIMIT));
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, reset corner sequence, and model-checked random traffic.
module tb_rf_write_arbiter;
  localparam int DATA_W       = 16;
  localparam int NREGS        = 16;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int NV           = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, issue_valid, mc_valid;
  logic [3:0]  wb_rd, issue_rd, mc_rd;
  logic [15:0] wb_data, mc_data;
  logic        mc_ready, rf_we, starve_stall;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata, busy;

  always #5 clk = ~clk;

  rf_write_arbiter #(
    .DATA_W(DATA_W), .NREGS(NREGS), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .starve_stall(starve_stall)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] busy;
    logic        stall;
  } obs_t;

  typedef struct packed {
    logic        wbv;
    logic [3:0]  wbrd;
    logic [15:0] wbd;
    logic        iv;
    logic [3:0]  ird;
    logic        mcv;
    logic [3:0]  mcrd;
    logic [15:0] mcd;
    obs_t        exp;
  } vec_t;

  localparam obs_t RST_OBS = '{we: 1'b0, waddr: 4'h0, wdata: 16'h0, ready: 1'b1, busy: 16'h0, stall: 1'b0};

  obs_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state
  logic [19:0] m_fifo[$];
  logic [15:0] m_busy;
  int          m_age;
  logic        m_we, m_stall;
  logic [3:0]  m_waddr;
  logic [15:0] m_wdata;

  task automatic compare(input string name, input obs_t a, input obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got we=%b waddr=%0d wdata=%h ready=%b busy=%h stall=%b, expected we=%b waddr=%0d wdata=%h ready=%b busy=%h stall=%b",
               name, a.we, a.waddr, a.wdata, a.ready, a.busy, a.stall,
               e.we, e.waddr, e.wdata, e.ready, e.busy, e.stall);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o = {rf_we, rf_waddr, rf_wdata, mc_ready, busy, starve_stall};
    return o;
  endfunction

  task automatic tick_check(input string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      compare(name, dut_obs(), exp_q.pop_front());
    end
  endtask

  task automatic drive(input logic wbv, input logic [3:0] wbrd, input logic [15:0] wbd,
                       input logic iv, input logic [3:0] ird,
                       input logic mcv, input logic [3:0] mcrd, input logic [15:0] mcd);
    wb_valid = wbv; wb_rd = wbrd; wb_data = wbd;
    issue_valid = iv; issue_rd = ird;
    mc_valid = mcv; mc_rd = mcrd; mc_data = mcd;
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_busy = '0; m_age = 0; m_we = 1'b0; m_stall = 1'b0;
    m_waddr = '0; m_wdata = '0;
  endtask

  // Computes next-cycle outputs from the currently driven inputs and queues them.
  task automatic model_step();
    bit          was_empty;
    bit          rdy;
    bit          pop;
    logic [19:0] head;
    obs_t        o;
    was_empty = (m_fifo.size() == 0);
    rdy       = (m_fifo.size() < DEPTH);
    pop       = !wb_valid && !was_empty;
    if (wb_valid) begin
      m_we = 1'b1; m_waddr = wb_rd; m_wdata = wb_data;
    end else if (pop) begin
      head = m_fifo.pop_front();
      m_we = 1'b1; m_waddr = head[19:16]; m_wdata = head[15:0];
      m_busy[head[19:16]] = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (issue_valid) m_busy[issue_rd] = 1'b1;
    if (pop || was_empty) m_age = 0;
    else if (m_age < STARVE_LIMIT) m_age++;
    m_stall = (m_age == STARVE_LIMIT);
    if (mc_valid && rdy) m_fifo.push_back({mc_rd, mc_data});
    o = {m_we, m_waddr, m_wdata, (m_fifo.size() < DEPTH), m_busy, m_stall};
    exp_q.push_back(o);
  endtask

  function automatic vec_t mk(input logic wbv, input logic [3:0] wbrd, input logic [15:0] wbd,
                              input logic iv, input logic [3:0] ird,
                              input logic mcv, input logic [3:0] mcrd, input logic [15:0] mcd,
                              input logic we, input logic [3:0] wa, input logic [15:0] wd,
                              input logic rdy, input logic [15:0] bsy, input logic st);
    vec_t v;
    v.wbv = wbv; v.wbrd = wbrd; v.wbd = wbd; v.iv = iv; v.ird = ird;
    v.mcv = mcv; v.mcrd = mcrd; v.mcd = mcd;
    v.exp = '{we: we, waddr: wa, wdata: wd, ready: rdy, busy: bsy, stall: st};
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [NV];
    //           wbv rd  wdata     iv ird mcv mrd mdata     we wa  wd        rdy busy      st
    tbl[0]  = mk(1, 3,  16'hBEEF, 0, 0, 0, 0,  16'h0000, 1, 3,  16'hBEEF, 1, 16'h0000, 0);
    tbl[1]  = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 0, 3,  16'hBEEF, 1, 16'h0000, 0);
    tbl[2]  = mk(0, 0,  16'h0000, 1, 5, 0, 0,  16'h0000, 0, 3,  16'hBEEF, 1, 16'h0020, 0);
    tbl[3]  = mk(0, 0,  16'h0000, 0, 0, 1, 5,  16'h1234, 0, 3,  16'hBEEF, 1, 16'h0020, 0);
    tbl[4]  = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 1, 5,  16'h1234, 1, 16'h0000, 0);
    tbl[5]  = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 0, 5,  16'h1234, 1, 16'h0000, 0);
    tbl[6]  = mk(0, 0,  16'h0000, 1, 7, 0, 0,  16'h0000, 0, 5,  16'h1234, 1, 16'h0080, 0);
    tbl[7]  = mk(0, 0,  16'h0000, 0, 0, 1, 7,  16'h0777, 0, 5,  16'h1234, 1, 16'h0080, 0);
    tbl[8]  = mk(0, 0,  16'h0000, 1, 7, 0, 0,  16'h0000, 1, 7,  16'h0777, 1, 16'h0080, 0);
    tbl[9]  = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 0, 7,  16'h0777, 1, 16'h0080, 0);
    tbl[10] = mk(1, 10, 16'hA000, 0, 0, 1, 1,  16'h1111, 1, 10, 16'hA000, 1, 16'h0080, 0);
    tbl[11] = mk(1, 11, 16'hA001, 0, 0, 1, 2,  16'h2222, 1, 11, 16'hA001, 0, 16'h0080, 0);
    tbl[12] = mk(1, 12, 16'hA002, 0, 0, 1, 3,  16'h3333, 1, 12, 16'hA002, 0, 16'h0080, 0);
    tbl[13] = mk(1, 13, 16'hA003, 0, 0, 0, 0,  16'h0000, 1, 13, 16'hA003, 0, 16'h0080, 0);
    tbl[14] = mk(1, 14, 16'hA004, 0, 0, 0, 0,  16'h0000, 1, 14, 16'hA004, 0, 16'h0080, 1);
    tbl[15] = mk(1, 15, 16'hA005, 0, 0, 0, 0,  16'h0000, 1, 15, 16'hA005, 0, 16'h0080, 1);
    tbl[16] = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 1, 1,  16'h1111, 1, 16'h0080, 0);
    tbl[17] = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 1, 2,  16'h2222, 1, 16'h0080, 0);
    tbl[18] = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 0, 2,  16'h2222, 1, 16'h0080, 0);
    tbl[19] = mk(1, 0,  16'h0000, 0, 0, 1, 4,  16'h4444, 1, 0,  16'h0000, 1, 16'h0080, 0);
    tbl[20] = mk(1, 0,  16'h0001, 0, 0, 1, 5,  16'h5555, 1, 0,  16'h0001, 0, 16'h0080, 0);
    tbl[21] = mk(0, 0,  16'h0000, 0, 0, 1, 6,  16'h6666, 1, 4,  16'h4444, 1, 16'h0080, 0);
    tbl[22] = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 1, 5,  16'h5555, 1, 16'h0080, 0);
    tbl[23] = mk(0, 0,  16'h0000, 0, 0, 0, 0,  16'h0000, 0, 5,  16'h5555, 1, 16'h0080, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    compare("reset_init", dut_obs(), RST_OBS);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Reset mid-run with two queued results
    drive(1, 4'd8, 16'h8888, 1, 4'd9, 1, 4'd9, 16'h9999);
    model_step();
    tick_check("t1_push1");
    drive(1, 4'd8, 16'h8889, 0, 4'd0, 1, 4'd10, 16'hAAAA);
    model_step();
    tick_check("t1_push2");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    compare("t1_async_reset", dut_obs(), RST_OBS);
    @(posedge clk);
    #1;
    compare("t1_reset_held", dut_obs(), RST_OBS);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_step();
      tick_check($sformatf("t1_idle%0d", i));
    end

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].wbv, tbl[i].wbrd, tbl[i].wbd, tbl[i].iv, tbl[i].ird,
            tbl[i].mcv, tbl[i].mcrd, tbl[i].mcd);
      exp_q.push_back(tbl[i].exp);
      tick_check($sformatf("vec%0d", i));
    end

    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Random traffic; a starving head gets a bubble like the hazard unit would insert
    for (int i = 0; i < 10000; i++) begin
      drive(starve_stall ? 1'b0 : ($urandom_range(0, 99) < 65),
            4'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 99) < 25), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 45), 4'($urandom_range(0, 15)), 16'($urandom));
      model_step();
      tick_check("random");
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
